vram_arbiter: RTL

//   Shares one single-port synchronous video RAM (two 64 B x 240-line bit planes: green, red)

---
 rtl/vram_arbiter_if.sv | 47 ++++
 rtl/vram_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter_if.sv
// Signal bundle between the VRAM arbiter, its clients (raster fetch, host)
// and the external single-port video RAM.
interface vram_arbiter_if #(
    parameter int ADDR_W = 15
);
    // Video fetch port
    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic [7:0]        vid_data;
    logic              vid_valid;

    // Host port
    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [7:0]        host_wdata;
    logic              host_ack;
    logic [7:0]        host_rdata;

    // External VRAM
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    // Status
    logic              vid_overrun;
    logic              host_starved;
    logic              status_clr;

    // Arbiter side
    modport slave (
        input  vid_req, vid_addr, host_req, host_we, host_addr, host_wdata,
               mem_rdata, status_clr,
        output vid_data, vid_valid, host_ack, host_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, vid_overrun, host_starved
    );

    // Client / memory side
    modport master (
        output vid_req, vid_addr, host_req, host_we, host_addr, host_wdata,
               mem_rdata, status_clr,
        input  vid_data, vid_valid, host_ack, host_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, vid_overrun, host_starved
    );
endinterface

// File: rtl/vram_arbiter.sv
// VRAM arbiter: one single-port synchronous VRAM shared between display
// scan-out (absolute priority, fixed 3-cycle latency) and a host port that
// fills idle slots. Four-stage pipeline: arbitrate, drive mem_*, capture
// mem_rdata, present result.
module vram_arbiter #(
    parameter int ADDR_W      = 15,
    parameter int VID_MIN_GAP = 8,
    parameter int HOST_TMO    = 64
) (
    input  logic          clk_pixel,
    input  logic          rst_n,
    vram_arbiter_if.slave bus
);
    localparam int GAP_W = $clog2(VID_MIN_GAP + 1);
    localparam int STV_W = $clog2(HOST_TMO + 1);
    localparam logic [GAP_W-1:0] GAP_SAT  = GAP_W'(VID_MIN_GAP);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
    localparam logic [STV_W-1:0] STV_LAST = STV_W'(HOST_TMO - 1);

    // Per-stage slot descriptor; valid=0 means an empty slot.
    typedef struct packed {
        logic valid;
        logic is_video;
        logic is_write;
    } tag_t;

    // Stage 0 decisions
    logic vid_grant;
    logic host_grant;
    logic host_wait;
    tag_t tag_d;

    // Stage 1: registered VRAM drive
    logic              mem_en_d,    mem_en_q;
    logic              mem_we_d,    mem_we_q;
    logic [ADDR_W-1:0] mem_addr_d,  mem_addr_q;
    logic [7:0]        mem_wdata_d, mem_wdata_q;
    tag_t              tag1_q;

    // Stage 2: slot whose read data is on mem_rdata
    tag_t              tag2_q;

    // Stage 3: results
    logic       vid_valid_d,  vid_valid_q;
    logic [7:0] vid_data_d,   vid_data_q;
    logic       host_ack_d,   host_ack_q;
    logic [7:0] host_rdata_d, host_rdata_q;

    // Bookkeeping
    logic             host_busy_d, host_busy_q;
    logic [GAP_W-1:0] gap_d,       gap_q;
    logic [STV_W-1:0] starve_d,    starve_q;
    logic             overrun_evt, starve_evt;
    logic             overrun_d,   overrun_q;
    logic             starved_d,   starved_q;

    // Arbitration: video always wins; host only when no access is outstanding.
    always_comb begin
        vid_grant      = bus.vid_req;
        host_grant     = !bus.vid_req && bus.host_req && !host_busy_q;
        host_wait      = bus.host_req && !host_busy_q && !host_grant;
        tag_d          = '0;
        tag_d.valid    = vid_grant || host_grant;
        tag_d.is_video = vid_grant;
        tag_d.is_write = host_grant && bus.host_we;
    end

    // Next VRAM drive; address/data hold their last value on idle slots.
    always_comb begin
        mem_en_d    = vid_grant || host_grant;
        mem_we_d    = host_grant && bus.host_we;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (vid_grant) begin
            mem_addr_d = bus.vid_addr;
        end else if (host_grant) begin
            mem_addr_d  = bus.host_addr;
            mem_wdata_d = bus.host_wdata;
        end
    end

    // Result stage: steer captured mem_rdata to the owner of the slot.
    always_comb begin
        vid_valid_d  = tag2_q.valid && tag2_q.is_video;
        vid_data_d   = vid_valid_d ? bus.mem_rdata : vid_data_q;
        host_ack_d   = tag2_q.valid && !tag2_q.is_video;
        host_rdata_d = (host_ack_d && !tag2_q.is_write) ? bus.mem_rdata : host_rdata_q;
    end

    // Host busy window, fetch-gap counter, starvation counter and sticky flags.
    always_comb begin
        host_busy_d = host_busy_q;
        if (host_ack_q) begin
            host_busy_d = 1'b0;
        end
        if (host_grant) begin
            host_busy_d = 1'b1;
        end

        overrun_evt = bus.vid_req && (gap_q < GAP_SAT);
        if (bus.vid_req) begin
            gap_d = GAP_ONE;
        end else if (gap_q == GAP_SAT) begin
            gap_d = gap_q;
        end else begin
            gap_d = gap_q + GAP_ONE;
        end

        starve_evt = host_wait && (starve_q == STV_LAST);
        if (!host_wait) begin
            starve_d = '0;
        end else if (starve_q == STV_LAST) begin
            starve_d = starve_q;
        end else begin
            starve_d = starve_q + STV_W'(1);
        end

        // A same-cycle event beats the clear.
        overrun_d = overrun_q;
        starved_d = starved_q;
        if (overrun_evt) begin
            overrun_d = 1'b1;
        end else if (bus.status_clr) begin
            overrun_d = 1'b0;
        end
        if (starve_evt) begin
            starved_d = 1'b1;
        end else if (bus.status_clr) begin
            starved_d = 1'b0;
        end
    end

    // Pipeline registers; reset empties every stage so no stale ack/valid appears.
    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            tag1_q       <= '0;
            tag2_q       <= '0;
            vid_valid_q  <= 1'b0;
            vid_data_q   <= '0;
            host_ack_q   <= 1'b0;
            host_rdata_q <= '0;
        end else begin
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            tag1_q       <= tag_d;
            tag2_q       <= tag1_q;
            vid_valid_q  <= vid_valid_d;
            vid_data_q   <= vid_data_d;
            host_ack_q   <= host_ack_d;
            host_rdata_q <= host_rdata_d;
        end
    end

    // Bookkeeping registers; gap counter starts saturated so the first fetch is clean.
    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            host_busy_q <= 1'b0;
            gap_q       <= GAP_SAT;
            starve_q    <= '0;
            overrun_q   <= 1'b0;
            starved_q   <= 1'b0;
        end else begin
            host_busy_q <= host_busy_d;
            gap_q       <= gap_d;
            starve_q    <= starve_d;
            overrun_q   <= overrun_d;
            starved_q   <= starved_d;
        end
    end

    assign bus.mem_en       = mem_en_q;
    assign bus.mem_we       = mem_we_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_wdata    = mem_wdata_q;
    assign bus.vid_valid    = vid_valid_q;
    assign bus.vid_data     = vid_data_q;
    assign bus.host_ack     = host_ack_q;
    assign bus.host_rdata   = host_rdata_q;
    assign bus.vid_overrun  = overrun_q;
    assign bus.host_starved = starved_q;
endmodule
